axi4_lite_master_adaptor: RTL and testbench

Self-running AXI4-Lite master that converts static request inputs (address, prot, data, strobe) into AXI4-Lite write and read transactions. It issues them back-to-back for as long as it is out of reset. The write path (AW/W/B) and the read path (AR/R) are two independent state machines sharing one clock. The block sits between local request registers and an AXI4-Lite slave or interconnect.

---
 rtl/axi4_lite_master_adaptor.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi4_lite_master_adaptor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_adaptor.sv
// Self-running AXI4-Lite master: repeatedly issues one write (AW/W/B) and one read (AR/R)
// built from static request inputs, using two independent FSMs with fully registered outputs.
module axi4_lite_master_adaptor (
    input  logic        aclk,
    input  logic        aresetn,

    output logic [31:0] awaddr_out,
    output logic [2:0]  awprot_out,
    output logic        awvalid_out,
    input  logic        awready_in,
    input  logic [31:0] awaddr_in,
    input  logic [2:0]  awprot_in,

    output logic [31:0] wdata_out,
    output logic [3:0]  wstrb_out,
    output logic        wvalid_out,
    input  logic        wready_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  wstrb_in,

    input  logic [1:0]  bresp_in,
    input  logic        bvalid_in,
    output logic        bready_out,

    output logic [31:0] araddr_out,
    output logic [2:0]  arprot_out,
    output logic        arvalid_out,
    input  logic        arready_in,
    input  logic [31:0] araddr_in,
    input  logic [2:0]  arprot_in,

    input  logic [31:0] rdata_in,
    input  logic [1:0]  rresp_in,
    input  logic        rvalid_in,
    output logic        rready_out
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR_DATA,
        W_RESP
    } wState_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rState_t;

    wState_t     wState_q, wState_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [2:0]  awprot_q, awprot_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;

    rState_t     rState_q, rState_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arprot_q, arprot_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;

    logic        awFire;
    logic        wFire;
    logic        awDone;
    logic        wDone;

    // Response and read data are consumed but intentionally never stored.
    logic        unusedInputs;
    assign unusedInputs = ^{bresp_in, rdata_in, rresp_in};

    // Each handshake is qualified by its own registered valid, so X/Z on a ready is harmless.
    assign awFire = awvalid_q & awready_in;
    assign wFire  = wvalid_q & wready_in;
    assign awDone = ~awvalid_q | awFire;
    assign wDone  = ~wvalid_q | wFire;

    // ---------------- Write path ----------------

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wState_q  <= W_IDLE;
            awaddr_q  <= '0;
            awprot_q  <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            wState_q  <= wState_d;
            awaddr_q  <= awaddr_d;
            awprot_q  <= awprot_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    always_comb begin
        wState_d = wState_q;
        case (wState_q)
            W_IDLE: begin
                wState_d = W_ADDR_DATA;
            end
            W_ADDR_DATA: begin
                if (awDone && wDone) begin
                    wState_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid_in) begin
                    wState_d = W_IDLE;
                end
            end
            default: begin
                wState_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        awaddr_d  = awaddr_q;
        awprot_d  = awprot_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        case (wState_q)
            W_IDLE: begin
                awaddr_d  = awaddr_in;
                awprot_d  = awprot_in;
                wdata_d   = wdata_in;
                wstrb_d   = wstrb_in;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end
            W_ADDR_DATA: begin
                if (awFire) begin
                    awvalid_d = 1'b0;
                end
                if (wFire) begin
                    wvalid_d = 1'b0;
                end
                if (awDone && wDone) begin
                    bready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (bvalid_in) begin
                    bready_d = 1'b0;
                end
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
    end

    // ---------------- Read path ----------------

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rState_q  <= R_IDLE;
            araddr_q  <= '0;
            arprot_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            rState_q  <= rState_d;
            araddr_q  <= araddr_d;
            arprot_q  <= arprot_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    always_comb begin
        rState_d = rState_q;
        case (rState_q)
            R_IDLE: begin
                rState_d = R_ADDR;
            end
            R_ADDR: begin
                if (arready_in) begin
                    rState_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_in) begin
                    rState_d = R_IDLE;
                end
            end
            default: begin
                rState_d = R_IDLE;
            end
        endcase
    end

    always_comb begin
        araddr_d  = araddr_q;
        arprot_d  = arprot_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (rState_q)
            R_IDLE: begin
                araddr_d  = araddr_in;
                arprot_d  = arprot_in;
                arvalid_d = 1'b1;
            end
            R_ADDR: begin
                if (arready_in) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            R_DATA: begin
                if (rvalid_in) begin
                    rready_d = 1'b0;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    assign awaddr_out  = awaddr_q;
    assign awprot_out  = awprot_q;
    assign awvalid_out = awvalid_q;
    assign wdata_out   = wdata_q;
    assign wstrb_out   = wstrb_q;
    assign wvalid_out  = wvalid_q;
    assign bready_out  = bready_q;
    assign araddr_out  = araddr_q;
    assign arprot_out  = arprot_q;
    assign arvalid_out = arvalid_q;
    assign rready_out  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_adaptor.sv
// Scoreboard bench for axi4_lite_master_adaptor: stimulus queues expected AW/W/AR payloads,
// a negedge monitor pops them on each handshake and checks B/R ordering.
module tb_axi4_lite_master_adaptor;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr_out;
    logic [2:0]  awprot_out;
    logic        awvalid_out;
    logic        awready_in;
    logic [31:0] awaddr_in;
    logic [2:0]  awprot_in;
    logic [31:0] wdata_out;
    logic [3:0]  wstrb_out;
    logic        wvalid_out;
    logic        wready_in;
    logic [31:0] wdata_in;
    logic [3:0]  wstrb_in;
    logic [1:0]  bresp_in;
    logic        bvalid_in;
    logic        bready_out;
    logic [31:0] araddr_out;
    logic [2:0]  arprot_out;
    logic        arvalid_out;
    logic        arready_in;
    logic [31:0] araddr_in;
    logic [2:0]  arprot_in;
    logic [31:0] rdata_in;
    logic [1:0]  rresp_in;
    logic        rvalid_in;
    logic        rready_out;

    int totalCount = 0;
    int badCount   = 0;
    int awCount = 0, wCount = 0, bCount = 0, arCount = 0, rCount = 0;

    logic [34:0] awQ[$];
    logic [35:0] wQ[$];
    logic [34:0] arQ[$];

    // Control vector order: {awvalid, wvalid, bready, arvalid, rready}
    logic [4:0] wrExp [6] = '{5'b00110, 5'b00010, 5'b11010, 5'b00110, 5'b00010, 5'b11010};
    logic [4:0] spExp [5] = '{5'b10010, 5'b10010, 5'b00110, 5'b00010, 5'b11010};
    logic [4:0] rdExp [6] = '{5'b11001, 5'b11000, 5'b11010, 5'b11001, 5'b11000, 5'b11010};

    axi4_lite_master_adaptor dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .awaddr_out  (awaddr_out),
        .awprot_out  (awprot_out),
        .awvalid_out (awvalid_out),
        .awready_in  (awready_in),
        .awaddr_in   (awaddr_in),
        .awprot_in   (awprot_in),
        .wdata_out   (wdata_out),
        .wstrb_out   (wstrb_out),
        .wvalid_out  (wvalid_out),
        .wready_in   (wready_in),
        .wdata_in    (wdata_in),
        .wstrb_in    (wstrb_in),
        .bresp_in    (bresp_in),
        .bvalid_in   (bvalid_in),
        .bready_out  (bready_out),
        .araddr_out  (araddr_out),
        .arprot_out  (arprot_out),
        .arvalid_out (arvalid_out),
        .arready_in  (arready_in),
        .araddr_in   (araddr_in),
        .arprot_in   (arprot_in),
        .rdata_in    (rdata_in),
        .rresp_in    (rresp_in),
        .rvalid_in   (rvalid_in),
        .rready_out  (rready_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [127:0] mkVec(
        input logic [31:0] awa, input logic [2:0] awp, input logic awv,
        input logic [31:0] wd, input logic [3:0] ws, input logic wv, input logic br,
        input logic [31:0] ara, input logic [2:0] arp, input logic arv, input logic rr);
        return {17'd0, awa, awp, awv, wd, ws, wv, br, ara, arp, arv, rr};
    endfunction

    function automatic logic [127:0] outVec();
        return {17'd0, awaddr_out, awprot_out, awvalid_out, wdata_out, wstrb_out, wvalid_out,
                bready_out, araddr_out, arprot_out, arvalid_out, rready_out};
    endfunction

    function automatic logic [4:0] ctrl();
        return {awvalid_out, wvalid_out, bready_out, arvalid_out, rready_out};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic awr, input logic wr, input logic bv,
                                 input logic arr, input logic rv);
        awready_in = awr;
        wready_in  = wr;
        bvalid_in  = bv;
        arready_in = arr;
        rvalid_in  = rv;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Handshakes are sampled at negedge; inputs only change 1ns after posedge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (awvalid_out && awready_in) begin
                if (awQ.size() == 0) checkOutput("aw_unexpected", 128'd1, 128'd0);
                else checkOutput("aw_payload", {awaddr_out, awprot_out}, awQ.pop_front());
                awCount++;
            end
            if (wvalid_out && wready_in) begin
                if (wQ.size() == 0) checkOutput("w_unexpected", 128'd1, 128'd0);
                else checkOutput("w_payload", {wdata_out, wstrb_out}, wQ.pop_front());
                wCount++;
            end
            if (arvalid_out && arready_in) begin
                if (arQ.size() == 0) checkOutput("ar_unexpected", 128'd1, 128'd0);
                else checkOutput("ar_payload", {araddr_out, arprot_out}, arQ.pop_front());
                arCount++;
            end
            if (bready_out) begin
                checkOutput("bready_with_valid", {126'd0, awvalid_out, wvalid_out}, 128'd0);
            end
            if (bready_out && bvalid_in) begin
                checkOutput("b_order", 128'((bCount < awCount) && (bCount < wCount)), 128'd1);
                bCount++;
            end
            if (rready_out && rvalid_in) begin
                checkOutput("r_order", 128'((rCount < arCount) && !arvalid_out), 128'd1);
                rCount++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn   = 1'b0;
        awaddr_in = 32'd16;
        awprot_in = 3'd4;
        wdata_in  = 32'hF0B4A596;
        wstrb_in  = 4'hB;
        araddr_in = 32'd16;
        arprot_in = 3'd4;
        bresp_in  = 2'd0;
        rresp_in  = 2'd0;
        rdata_in  = 32'd0;
        applyStimulus(0, 0, 0, 0, 0);

        repeat (3) tick();
        checkOutput("reset_zero", outVec(), 128'd0);

        aresetn = 1'b1;
        tick();
        checkOutput("release_ctrl", {123'd0, ctrl()}, {123'd0, 5'b11010});
        checkOutput("release_vec", outVec(),
            mkVec(32'd16, 3'd4, 1'b1, 32'hF0B4A596, 4'hB, 1'b1, 1'b0, 32'd16, 3'd4, 1'b1, 1'b0));

        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("stall%0d", i), outVec(),
                mkVec(32'd16, 3'd4, 1'b1, 32'hF0B4A596, 4'hB, 1'b1, 1'b0, 32'd16, 3'd4, 1'b1, 1'b0));
        end

        repeat (2) begin
            awQ.push_back({32'd16, 3'd4});
            wQ.push_back({32'hF0B4A596, 4'hB});
        end
        applyStimulus(1, 1, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("write_ctrl%0d", k), {123'd0, ctrl()}, {123'd0, wrExp[k]});
        end
        applyStimulus(0, 0, 0, 0, 0);

        awaddr_in = 32'd32;
        awQ.push_back({32'd16, 3'd4});
        wQ.push_back({32'hF0B4A596, 4'hB});
        applyStimulus(0, 1, 1, 0, 0);
        tick();
        checkOutput("split_ctrl0", {123'd0, ctrl()}, {123'd0, spExp[0]});
        tick();
        checkOutput("split_ctrl1", {123'd0, ctrl()}, {123'd0, spExp[1]});
        checkOutput("split_awaddr_hold", {96'd0, awaddr_out}, 128'd16);
        applyStimulus(1, 1, 1, 0, 0);
        tick();
        checkOutput("split_ctrl2", {123'd0, ctrl()}, {123'd0, spExp[2]});
        tick();
        checkOutput("split_ctrl3", {123'd0, ctrl()}, {123'd0, spExp[3]});
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        checkOutput("split_ctrl4", {123'd0, ctrl()}, {123'd0, spExp[4]});
        checkOutput("split_awaddr_new", {96'd0, awaddr_out}, 128'd32);

        araddr_in = 32'd48;
        arprot_in = 3'd2;
        rdata_in  = 32'hF0B4A596;
        arQ.push_back({32'd16, 3'd4});
        arQ.push_back({32'd48, 3'd2});
        applyStimulus(0, 0, 0, 1, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("read_ctrl%0d", k), {123'd0, ctrl()}, {123'd0, rdExp[k]});
        end
        applyStimulus(0, 0, 0, 0, 0);

        awQ.push_back({32'd32, 3'd4});
        wQ.push_back({32'hF0B4A596, 4'hB});
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        checkOutput("wresp_ctrl", {123'd0, ctrl()}, {123'd0, 5'b00110});
        applyStimulus(0, 0, 0, 0, 0);
        aresetn = 1'b0;
        tick();
        checkOutput("reset_in_wresp", outVec(), 128'd0);
        aresetn = 1'b1;
        tick();
        checkOutput("rerelease_vec", outVec(),
            mkVec(32'd32, 3'd4, 1'b1, 32'hF0B4A596, 4'hB, 1'b1, 1'b0, 32'd48, 3'd2, 1'b1, 1'b0));
        repeat (2) tick();

        checkOutput("aw_count", 128'(awCount), 128'd4);
        checkOutput("w_count", 128'(wCount), 128'd4);
        checkOutput("b_count", 128'(bCount), 128'd3);
        checkOutput("ar_count", 128'(arCount), 128'd2);
        checkOutput("r_count", 128'(rCount), 128'd2);
        checkOutput("queues_empty", 128'(awQ.size() + wQ.size() + arQ.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
